// File: rtl/lcd1602_pkg.sv
// Shared HD44780/LCD1602 command codes, DDRAM address map and address-counter stepping.
// Used by both the LCD text controller and the bus receiver.
package lcd1602_pkg;

   localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
   localparam logic [7:0] RETURN_HOME   = 8'h02;
   localparam logic [7:0] ENTRY_MODE    = 8'h04;
   localparam logic [7:0] DISPLAY_CTRL  = 8'h08;
   localparam logic [7:0] CURSOR_SHIFT  = 8'h10;
   localparam logic [7:0] FUNCTION_SET  = 8'h20;
   localparam logic [7:0] SET_CGRAM     = 8'h40;
   localparam logic [7:0] SET_DDRAM     = 8'h80;
   localparam logic [7:0] START_2LINE   = 8'hC0;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [6:0] LINE0_WRAP = 7'h27;
   localparam logic [6:0] LINE1_WRAP = 7'h67;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   typedef enum logic {S_IDLE, S_CLEAR} rx_state_t;

   // DDRAM address counter step; each line wraps into the other line's base.
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      if (inc) begin
         if (a == LINE0_WRAP) return LINE1_BASE;
         if (a == LINE1_WRAP) return LINE0_BASE;
         return a + 7'd1;
      end
      if (a == LINE0_BASE) return LINE1_WRAP;
      if (a == LINE1_BASE) return LINE0_WRAP;
      return a - 7'd1;
   endfunction

endpackage

// File: rtl/lcd1602_rx_if.sv
// LCD1602 parallel bus: the controller drives it as master, the receiver samples it as slave.
interface lcd1602_rx_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data);
  modport slave  (input  lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizes all 11 bus bits through one shared chain so RS/RW/DATA stay aligned
// with E, then flags each synchronized E falling edge as a one-cycle strobe.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  output logic       strobe,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  logic [10:0] sync_q [SYNC_STAGES];
  logic        e_sync;
  logic        e_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_prev <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev <= e_sync;
    end
  end

  assign {rs, rw, e_sync, data} = sync_q[SYNC_STAGES-1];
  assign strobe = e_prev & ~e_sync;

endmodule

// File: rtl/lcd1602_rx.sv
// LCD1602 bus receiver: decodes controller writes into a 2 x COLS character buffer
// plus display-control state, and exposes the buffer through a registered read port.
//   state   | meaning
//   S_CLEAR | busy: blanking one buffer cell per cycle, ascending from cell 0
//   S_IDLE  | accepting bus writes
module lcd1602_rx
  import lcd1602_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd1602_rx_if.slave             bus,
  input  logic                    rd_line,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [7:0]              rd_char,
  output logic [6:0]              ac,
  output logic                    disp_on,
  output logic                    cursor_on,
  output logic                    blink_on,
  output logic                    entry_inc,
  output logic                    two_line,
  output logic                    mode_8bit,
  output logic                    busy,
  output logic                    wr_strobe,
  output logic                    wr_is_data,
  output logic [7:0]              wr_byte,
  output logic                    overrun,
  output logic                    unsupported
);

  localparam int CELLS = 2 * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam logic [IW-1:0] LAST_CELL = IW'(CELLS - 1);

  rx_state_t     state, state_nx;
  logic [IW-1:0] clr_left;
  logic [7:0]    buf_q [CELLS];
  logic          strobe, s_rs, s_rw;
  logic [7:0]    s_data;
  logic          clr_done, accept, cmd_clear, data_we;
  logic [IW-1:0] data_idx, clr_idx, rd_idx;

  // Both lines hold columns 0..COLS-1 in the low six address bits; bit 6 picks the line.
  function automatic logic visible(input logic [6:0] a);
    return int'(a[5:0]) < COLS;
  endfunction

  function automatic logic [IW-1:0] cell_of(input logic [6:0] a);
    return IW'(int'(a[6]) * COLS + int'(a[5:0]));
  endfunction

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .lcd_rs   (bus.lcd_rs),
    .lcd_rw   (bus.lcd_rw),
    .lcd_e    (bus.lcd_e),
    .lcd_data (bus.lcd_data),
    .strobe   (strobe),
    .rs       (s_rs),
    .rw       (s_rw),
    .data     (s_data)
  );

  // The last clear cycle already accepts a strobe, so back-to-back traffic loses nothing.
  always_comb begin
    clr_done  = (state == S_CLEAR) && (clr_left == '0);
    accept    = strobe && !s_rw && ((state == S_IDLE) || clr_done);
    cmd_clear = accept && !s_rs && (s_data == CLEAR_DISPLAY);
    data_we   = accept && s_rs && visible(ac);
    data_idx  = cell_of(ac);
    clr_idx   = LAST_CELL - clr_left;
    rd_idx    = IW'(int'(rd_line) * COLS + int'(rd_col));
  end

  always_comb begin
    state_nx = state;
    if (cmd_clear)     state_nx = S_CLEAR;
    else if (clr_done) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_CLEAR;
      clr_left <= LAST_CELL;
    end else begin
      state <= state_nx;
      if (cmd_clear)                         clr_left <= LAST_CELL;
      else if (state == S_CLEAR && !clr_done) clr_left <= clr_left - 1'b1;
    end
  end

  assign busy = (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) buf_q[clr_idx] <= BLANK_CHAR;
    if (data_we)          buf_q[data_idx] <= s_data;
    rd_char <= buf_q[rd_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac          <= '0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      entry_inc   <= 1'b1;
      two_line    <= 1'b0;
      mode_8bit   <= 1'b1;
      wr_strobe   <= 1'b0;
      wr_is_data  <= 1'b0;
      wr_byte     <= '0;
      overrun     <= 1'b0;
      unsupported <= 1'b0;
    end else begin
      wr_strobe <= accept;
      if (strobe && s_rw)         unsupported <= 1'b1;
      else if (strobe && !accept) overrun     <= 1'b1;
      if (accept) begin
        wr_is_data <= s_rs;
        wr_byte    <= s_data;
        if (s_rs) begin
          ac <= ac_step(ac, entry_inc);
        end else if (|(s_data & SET_DDRAM)) begin
          ac <= s_data[6:0];
        end else if (|(s_data & SET_CGRAM)) begin
          unsupported <= 1'b1;
        end else if (|(s_data & FUNCTION_SET)) begin
          mode_8bit <= s_data[4];
          two_line  <= s_data[3];
        end else if (|(s_data & CURSOR_SHIFT)) begin
          if (!s_data[3]) ac <= ac_step(ac, s_data[2]);
        end else if (|(s_data & DISPLAY_CTRL)) begin
          {disp_on, cursor_on, blink_on} <= s_data[2:0];
        end else if (|(s_data & ENTRY_MODE)) begin
          entry_inc <= s_data[1];
        end else if (|(s_data & RETURN_HOME)) begin
          ac <= '0;
        end else if (|(s_data & CLEAR_DISPLAY)) begin
          ac        <= '0;
          entry_inc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lcd1602_rx.md
# lcd1602_rx

Receiving end of the 8-bit HD44780/LCD1602 parallel bus driven by the team's LCD text controller. It samples `lcd_rs`, `lcd_rw`, `lcd_e` and `lcd_data` on the falling edge of E and decodes instructions and characters. It maintains a 2×COLS character buffer plus display-control state, and exposes the buffer through a read port. It serves as a scoreboard model in controller testbenches and as the source for an on-board display mirror, for example a VGA overlay.

## Interface
- `COLS`, 16, visible columns per line (1..40)
- `SYNC_STAGES`, 2, synchronizer depth on all bus inputs (≥2)
- `clk` in 1, system clock
- `reset` in 1, asynchronous, active-high
- `lcd_rs` / `lcd_rw` / `lcd_e` in 1 each, bus controls (asynchronous to `clk`)
- `lcd_data` in 8, bus data
- `rd_line` in 1, read line select
- `rd_col` in clog2(COLS), read column
- `rd_char` out 8, buffer byte at (`rd_line`,`rd_col`), 1-cycle latency
- `ac` out 7, DDRAM address counter
- `disp_on`, `cursor_on`, `blink_on`, `entry_inc`, `two_line`, `mode_8bit` out 1 each, decoded control state
- `busy` out 1, clear in progress
- `wr_strobe` out 1, one-cycle pulse per accepted bus write
- `wr_is_data` out 1, RS value of the accepted write
- `wr_byte` out 8, byte of the accepted write
- `overrun` out 1, sticky: a strobe arrived while busy
- `unsupported` out 1, sticky: a CGRAM-address command or a strobe with RW=1 was received

## Operation
- All four bus inputs pass through the same SYNC_STAGES flops, so RS, RW and DATA stay aligned with E. A strobe is a synchronized E transition 1→0, sampled together with the aligned RS, RW and DATA.
- RW=1 strobe: set `unsupported`. No other state change and no `wr_strobe`.
- Strobe while `busy`: drop it and set `overrun`. No `wr_strobe`.
- RS=1 (data): write DDRAM[ac] if ac is visible, then step ac.
- RS=0 (instruction), decoded by highest set bit:
  - 1aaaaaaa: ac ← a.
  - 01xxxxxx: set `unsupported`; no other change.
  - 001 DL N F: `mode_8bit`←DL, `two_line`←N. F is ignored.
  - 0001 SC RL x: if SC=0, step ac right (RL=1) or left (RL=0). If SC=1, nothing changes.
  - 00001 D C B: `disp_on`, `cursor_on`, `blink_on`.
  - 000001 ID S: `entry_inc`←ID. S is ignored.
  - 0000001x: ac←0.
  - 00000001: start a clear: ac←0, `entry_inc`←1, `busy` for 2·COLS cycles, writing 0x20 to one buffer cell per cycle in ascending order.
  - 0x00: no operation, but still reported on `wr_strobe`.
- Visible addresses: 0x00..COLS-1 map to line 0, and 0x40..0x40+COLS-1 map to line 1. Writes to other addresses advance ac without storing.
- Increment rule: 0x27→0x40 and 0x67→0x00; any other value +1 mod 128.
- Decrement rule: 0x00→0x67 and 0x40→0x27; any other value −1 mod 128.
- Reset values: ac=0, `disp_on`=0, `cursor_on`=0, `blink_on`=0, `entry_inc`=1, `two_line`=0, `mode_8bit`=1, `wr_strobe`=0, `wr_is_data`=0, `wr_byte`=0x00, `overrun`=0, `unsupported`=0, `busy`=1.
- After reset deasserts, an automatic clear runs: the buffer is filled with 0x20 and `busy` drops after 2·COLS cycles.
- Reset asserted mid-clear aborts the clear. The clear restarts from cell 0 after release.

## Timing
- Strobe latency: the E falling edge is detected SYNC_STAGES+1 clk edges after the first edge that samples E low.
- On the detection edge, all register, ac and buffer updates occur together, and `wr_strobe`, `wr_is_data` and `wr_byte` are valid for exactly one cycle.
- `rd_char` reflects a buffer write one cycle after the detection edge.
- The bus master must hold RS, RW and DATA stable for at least SYNC_STAGES+1 clk cycles on each side of the E falling edge, and keep E high and low for at least SYNC_STAGES+1 cycles each. The team's controller changes DATA on the E rising edge, which satisfies this.
- A clear command sets `busy` on the detection edge. `busy` stays high for 2·COLS cycles.
- A strobe detected in the same cycle `busy` deasserts is accepted.

## Structure
- Shared package `lcd1602_pkg` holds:
  - command codes (CLEAR_DISPLAY, RETURN_HOME, entry, display, shift, function and set-DDRAM prefixes, START_2LINE);
  - line bases 0x00/0x40, wrap limits 0x27/0x67, and blank char 0x20.
- The controller and this block both use the package.
- Sub-module `lcd_bus_sync`: a SYNC_STAGES synchronizer for the 11 bus bits plus an E falling-edge detector. It outputs a one-cycle `strobe` and the aligned `rs`, `rw`, `data`.

## Test plan
- Reset, then 0x38, 0x06, 0x0C, 0x01 → `two_line`=1, `mode_8bit`=1, `entry_inc`=1, `disp_on`=1, `cursor_on`=0; `busy` high 32 cycles; all cells 0x20; ac=0.
- 0x80, then data 0x48, 0x49 → (0,0)=0x48, (0,1)=0x49, ac=0x02, two `wr_strobe` pulses with `wr_is_data`=1.
- 0xA7, then data 0x41 → nothing stored, ac=0x40. 0xC0 plus 16 data bytes → line 1 filled, ac=0x50.
- 0x04, 0x80, data 0x5A → (0,0)=0x5A, ac=0x67. Then 0x14 → ac=0x00.
- 0x01, then a data strobe 5 cycles later → strobe dropped, `overrun`=1, buffer all 0x20 after `busy` falls.
- RW=1 strobe → `unsupported`=1, no `wr_strobe`. Reset pulse mid-clear → `busy` reasserts for the full 32 cycles after release.
